// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// and a saturating count of inserted hazard bubbles.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    ctlwb_in,
  input  logic [2:0]    ctlm_in,
  input  logic [3:0]    ctlex_in,
  input  logic [DW-1:0] npc_in,
  input  logic [DW-1:0] rdata1_in,
  input  logic [DW-1:0] rdata2_in,
  input  logic [DW-1:0] signext_in,
  input  logic [4:0]    rt_in,
  input  logic [4:0]    rd_in,
  input  logic [4:0]    ifid_rs,
  input  logic [4:0]    ifid_rt,
  input  logic          flush,
  output logic [1:0]    wb_out,
  output logic [2:0]    m_out,
  output logic [3:0]    ex_out,
  output logic [DW-1:0] npc_out,
  output logic [DW-1:0] rdata1_out,
  output logic [DW-1:0] rdata2_out,
  output logic [DW-1:0] signext_out,
  output logic [4:0]    rt_out,
  output logic [4:0]    rd_out,
  output logic          valid_out,
  output logic          stall_out,
  output logic [CW-1:0] stall_count
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  // Initialisers give a zero power-up state in simulation; rst clears them in hardware.
  logic [1:0]    wb_q      = '0;
  logic [2:0]    m_q       = '0;
  logic [3:0]    ex_q      = '0;
  logic [DW-1:0] npc_q     = '0;
  logic [DW-1:0] rdata1_q  = '0;
  logic [DW-1:0] rdata2_q  = '0;
  logic [DW-1:0] signext_q = '0;
  logic [4:0]    rt_q      = '0;
  logic [4:0]    rd_q      = '0;
  logic          valid_q   = 1'b0;
  logic [CW-1:0] count_q   = '0;
  logic          hazard;

  // A load in EX whose destination is read by the instruction in IF/ID.
  assign hazard = valid_q & m_q[1] & (rt_q != 5'd0) &
                  ((rt_q == ifid_rs) | (rt_q == ifid_rt));

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q      <= '0;
      m_q       <= '0;
      ex_q      <= '0;
      npc_q     <= '0;
      rdata1_q  <= '0;
      rdata2_q  <= '0;
      signext_q <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      valid_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      npc_q     <= npc_in;
      rdata1_q  <= rdata1_in;
      rdata2_q  <= rdata2_in;
      signext_q <= signext_in;
      rt_q      <= rt_in;
      rd_q      <= rd_in;
      if (flush || hazard) begin
        wb_q    <= '0;
        m_q     <= '0;
        ex_q    <= '0;
        valid_q <= 1'b0;
      end else begin
        wb_q    <= ctlwb_in;
        m_q     <= ctlm_in;
        ex_q    <= ctlex_in;
        valid_q <= 1'b1;
      end
      // A flush already squashes the slot, so only pure hazard bubbles are counted.
      if (hazard && !flush && (count_q != CNT_MAX)) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign wb_out      = wb_q;
  assign m_out       = m_q;
  assign ex_out      = ex_q;
  assign npc_out     = npc_q;
  assign rdata1_out  = rdata1_q;
  assign rdata2_out  = rdata2_q;
  assign signext_out = signext_q;
  assign rt_out      = rt_q;
  assign rd_out      = rd_q;
  assign valid_out   = valid_q;
  assign stall_out   = hazard;
  assign stall_count = count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a behavioural model predicts each
// post-edge state, which is queued at drive time and compared after the edge.
module tb_id_ex_stage;

  typedef struct packed {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [3:0]  ex;
    logic [31:0] npc;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] se;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        valid;
    logic [7:0]  cnt;
  } state_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ctlwb_in;
  logic [2:0]  ctlm_in;
  logic [3:0]  ctlex_in;
  logic [31:0] npc_in, rdata1_in, rdata2_in, signext_in;
  logic [4:0]  rt_in, rd_in, ifid_rs, ifid_rt;
  logic        flush;
  logic [1:0]  wb_out;
  logic [2:0]  m_out;
  logic [3:0]  ex_out;
  logic [31:0] npc_out, rdata1_out, rdata2_out, signext_out;
  logic [4:0]  rt_out, rd_out;
  logic        valid_out, stall_out;
  logic [7:0]  stall_count;

  int     checkCount = 0;
  int     failCount  = 0;
  state_t mdl = '0;
  state_t sb[$];

  id_ex_stage #(.DW(32), .CW(8)) dut (
    .clk(clk), .rst(rst),
    .ctlwb_in(ctlwb_in), .ctlm_in(ctlm_in), .ctlex_in(ctlex_in),
    .npc_in(npc_in), .rdata1_in(rdata1_in), .rdata2_in(rdata2_in), .signext_in(signext_in),
    .rt_in(rt_in), .rd_in(rd_in), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .flush(flush),
    .wb_out(wb_out), .m_out(m_out), .ex_out(ex_out),
    .npc_out(npc_out), .rdata1_out(rdata1_out), .rdata2_out(rdata2_out), .signext_out(signext_out),
    .rt_out(rt_out), .rd_out(rd_out), .valid_out(valid_out),
    .stall_out(stall_out), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [159:0] act, input logic [159:0] exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic modelStall(input state_t s, input logic [4:0] rs, input logic [4:0] rt);
    return s.valid && s.m[1] && (s.rt != 5'd0) && ((s.rt == rs) || (s.rt == rt));
  endfunction

  function automatic state_t dutState();
    return {wb_out, m_out, ex_out, npc_out, rdata1_out, rdata2_out, signext_out,
            rt_out, rd_out, valid_out, stall_count};
  endfunction

  // Drive one cycle of inputs, predict the next state, then compare after the edge.
  task automatic applyStimulus(input logic r, input logic f, input logic [1:0] wb,
                               input logic [2:0] m, input logic [3:0] ex,
                               input logic [4:0] rt, input logic [4:0] rd,
                               input logic [4:0] rs_f, input logic [4:0] rt_f,
                               input logic [31:0] r1);
    logic   expStall;
    state_t nxt;
    @(negedge clk);
    rst = r; flush = f; ctlwb_in = wb; ctlm_in = m; ctlex_in = ex;
    rt_in = rt; rd_in = rd; ifid_rs = rs_f; ifid_rt = rt_f;
    rdata1_in = r1; npc_in = $urandom; rdata2_in = $urandom; signext_in = $urandom;
    #1;
    expStall = modelStall(mdl, rs_f, rt_f);
    checkOutput("stall_pre", stall_out, expStall);
    nxt = mdl;
    if (r) begin
      nxt = '0;
    end else begin
      nxt.npc = npc_in; nxt.r1 = r1; nxt.r2 = rdata2_in; nxt.se = signext_in;
      nxt.rt = rt; nxt.rd = rd;
      if (f || expStall) begin
        nxt.wb = '0; nxt.m = '0; nxt.ex = '0; nxt.valid = 1'b0;
      end else begin
        nxt.wb = wb; nxt.m = m; nxt.ex = ex; nxt.valid = 1'b1;
      end
      if (expStall && !f && mdl.cnt != 8'd255) nxt.cnt = mdl.cnt + 8'd1;
    end
    mdl = nxt;
    sb.push_back(nxt);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checkOutput("sb_empty", 1'b1, 1'b0);
    end else begin
      state_t e;
      e = sb.pop_front();
      checkOutput("state", dutState(), e);
      checkOutput("stall_post", stall_out, modelStall(e, rs_f, rt_f));
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ctlwb_in = '0; ctlm_in = '0; ctlex_in = '0;
    npc_in = '0; rdata1_in = '0; rdata2_in = '0; signext_in = '0;
    rt_in = '0; rd_in = '0; ifid_rs = '0; ifid_rt = '0;

    // Reset held two cycles with random inputs
    for (int i = 0; i < 2; i++)
      applyStimulus(1'b1, 1'($urandom), 2'($urandom), 3'($urandom), 4'($urandom),
                    5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
    checkOutput("rst_valid", valid_out, 1'b0);
    checkOutput("rst_cnt", stall_count, 8'd0);
    checkOutput("rst_stall", stall_out, 1'b0);
    checkOutput("rst_ctl", {wb_out, m_out, ex_out}, 9'd0);

    // R-type load
    applyStimulus(1'b0, 1'b0, 2'b10, 3'b000, 4'b1100, 5'd5, 5'd7, 5'd1, 5'd2, 32'h11);
    checkOutput("rtype_valid", valid_out, 1'b1);
    checkOutput("rtype_ex", ex_out, 4'b1100);
    checkOutput("rtype_r1", rdata1_out, 32'h11);
    checkOutput("rtype_rtrd", {rt_out, rd_out}, {5'd5, 5'd7});

    // LW rt=8 followed by a dependent instruction
    applyStimulus(1'b0, 1'b0, 2'b11, 3'b010, 4'b0011, 5'd8, 5'd0, 5'd1, 5'd2, $urandom);
    checkOutput("lw_m", m_out, 3'b010);
    applyStimulus(1'b0, 1'b0, 2'b10, 3'b000, 4'b1100, 5'd3, 5'd4, 5'd8, 5'd2, $urandom);
    checkOutput("bubble_ctl", {wb_out, m_out, ex_out}, 9'd0);
    checkOutput("bubble_valid", valid_out, 1'b0);
    checkOutput("bubble_cnt", stall_count, 8'd1);
    checkOutput("bubble_stall", stall_out, 1'b0);

    // LW to r0 must not stall
    applyStimulus(1'b0, 1'b0, 2'b11, 3'b010, 4'b0011, 5'd0, 5'd0, 5'd1, 5'd2, $urandom);
    applyStimulus(1'b0, 1'b0, 2'b10, 3'b000, 4'b1100, 5'd3, 5'd4, 5'd3, 5'd0, $urandom);
    checkOutput("r0_cnt", stall_count, 8'd1);
    checkOutput("r0_valid", valid_out, 1'b1);

    // SW with matching rt must not stall
    applyStimulus(1'b0, 1'b0, 2'b00, 3'b001, 4'b0001, 5'd9, 5'd0, 5'd1, 5'd2, $urandom);
    applyStimulus(1'b0, 1'b0, 2'b10, 3'b000, 4'b1100, 5'd3, 5'd4, 5'd9, 5'd9, $urandom);
    checkOutput("sw_valid", valid_out, 1'b1);

    // Flush coincident with a hazard, then flush alone
    applyStimulus(1'b0, 1'b0, 2'b11, 3'b010, 4'b0011, 5'd10, 5'd0, 5'd1, 5'd2, $urandom);
    applyStimulus(1'b0, 1'b1, 2'b10, 3'b000, 4'b1100, 5'd3, 5'd4, 5'd10, 5'd2, $urandom);
    checkOutput("flushstall_cnt", stall_count, 8'd1);
    checkOutput("flushstall_valid", valid_out, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'b10, 3'b000, 4'b1100, 5'd3, 5'd4, 5'd1, 5'd2, $urandom);
    applyStimulus(1'b0, 1'b1, 2'b10, 3'b000, 4'b1100, 5'd3, 5'd4, 5'd1, 5'd2, $urandom);
    checkOutput("flush_valid", valid_out, 1'b0);

    // NOP encoding is a real instruction
    applyStimulus(1'b0, 1'b0, 2'b00, 3'b100, 4'b0010, 5'd0, 5'd0, 5'd1, 5'd2, $urandom);
    checkOutput("nop_valid", valid_out, 1'b1);
    checkOutput("nop_m", m_out, 3'b100);

    // Random traffic with a small register space to provoke hazards
    for (int i = 0; i < 200; i++)
      applyStimulus(1'($urandom_range(19) == 0), 1'($urandom_range(7) == 0),
                    2'($urandom), 3'($urandom), 4'($urandom),
                    5'($urandom_range(3)), 5'($urandom_range(3)),
                    5'($urandom_range(3)), 5'($urandom_range(3)), $urandom);

    // Saturation: a held LW with a dependent consumer alternates load/bubble
    applyStimulus(1'b1, 1'b0, 2'b00, 3'b000, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, $urandom);
    for (int i = 0; i < 600; i++)
      applyStimulus(1'b0, 1'b0, 2'b11, 3'b010, 4'b0011, 5'd4, 5'd0, 5'd4, 5'd0, $urandom);
    checkOutput("sat_cnt", stall_count, 8'd255);
    applyStimulus(1'b0, 1'b0, 2'b11, 3'b010, 4'b0011, 5'd4, 5'd0, 5'd4, 5'd0, $urandom);
    checkOutput("sat_hold", stall_count, 8'd255);
    applyStimulus(1'b1, 1'b0, 2'b11, 3'b010, 4'b0011, 5'd4, 5'd0, 5'd4, 5'd0, $urandom);
    checkOutput("sat_rst", stall_count, 8'd0);

    // Reset while a hazard is pending wins and records nothing
    applyStimulus(1'b0, 1'b0, 2'b11, 3'b010, 4'b0011, 5'd6, 5'd0, 5'd6, 5'd0, $urandom);
    applyStimulus(1'b0, 1'b0, 2'b11, 3'b010, 4'b0011, 5'd6, 5'd0, 5'd6, 5'd0, $urandom);
    checkOutput("mid_cnt1", stall_count, 8'd1);
    applyStimulus(1'b0, 1'b0, 2'b11, 3'b010, 4'b0011, 5'd6, 5'd0, 5'd6, 5'd0, $urandom);
    applyStimulus(1'b1, 1'b0, 2'b11, 3'b010, 4'b0011, 5'd6, 5'd0, 5'd6, 5'd0, $urandom);
    checkOutput("midrst_cnt", stall_count, 8'd0);
    checkOutput("midrst_valid", valid_out, 1'b0);

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
